shift_unit_seq: RTL

- Iterative, multi-cycle shift/rotate unit for the execute stage.
- Supports all four ARM shift types: LSL, LSR, ASR and ROR.
- Shifts at most STEP bit positions per clock, trading latency for area against the single-cycle barrel shifter.
- Uses a valid/ready handshake on both the operand side and the result side, so the pipeline stalls cleanly while an operation is in flight.

---
 rtl/shift_unit_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/shift_unit_seq.sv
// Iterative shift/rotate unit: LSL, LSR, ASR and ROR, at most STEP
// bit positions per clock, with valid/ready handshakes on both sides.
module shift_unit_seq #(
   parameter int WIDTH = 64,
   parameter int STEP  = 4,
   parameter int DW    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] value,
   input  logic [1:0]       op,
   input  logic [DW-1:0]    distance,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   // Largest step that can ever be applied; distance never reaches WIDTH.
   localparam int KMAX = (STEP < WIDTH) ? STEP : WIDTH - 1;

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg;
   logic [1:0]       op_reg;
   logic [DW-1:0]    rem_reg;
   logic [DW-1:0]    k;
   logic [DW-1:0]    rem_after;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] cand [0:KMAX];

   // Step size for this cycle: a full STEP, or whatever remains if less.
   always_comb begin
      if ({1'b0, rem_reg} < (DW+1)'(KMAX)) begin
         k = rem_reg;
      end else begin
         k = DW'(KMAX);
      end
   end

   assign rem_after = rem_reg - k;

   // One fixed-distance candidate per possible step size; the selected
   // candidate becomes the next working value. ASR fills from the MSB of
   // the current working value, so the sign carries across steps.
   genvar gi;
   generate
      for (gi = 0; gi <= KMAX; gi++) begin : g_cand
         localparam int RS = (gi == 0) ? 0 : WIDTH - gi;
         logic [WIDTH-1:0] lsl_v, lsr_v, asr_v, ror_v;
         assign lsl_v = result_reg << gi;
         assign lsr_v = result_reg >> gi;
         assign asr_v = WIDTH'($signed(result_reg) >>> gi);
         assign ror_v = (result_reg >> gi) | (result_reg << RS);
         assign cand[gi] = (op_reg == OP_LSL) ? lsl_v :
                           (op_reg == OP_LSR) ? lsr_v :
                           (op_reg == OP_ASR) ? asr_v : ror_v;
      end
   endgenerate

   // Pick the candidate matching the current step size.
   always_comb begin
      step_val = result_reg;
      for (int i = 0; i <= KMAX; i++) begin
         if (k == DW'(i)) begin
            step_val = cand[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = (state_reg != IDLE);
      unique case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = (distance != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (rem_after == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Working register, op and remaining distance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_reg <= '0;
         op_reg     <= 2'b00;
         rem_reg    <= '0;
      end else begin
         if (state_reg == IDLE && in_valid) begin
            result_reg <= value;
            op_reg     <= op;
            rem_reg    <= distance;
         end else if (state_reg == SHIFT) begin
            result_reg <= step_val;
            rem_reg    <= rem_after;
         end
      end
   end

   assign result = result_reg;

endmodule
